onehot_scan_decoder: RTL and testbench

Parametrised, registered binary-to-one-hot decoder with enable and an auto-scan mode. It generalises the 2-to-4 enabled decoder to 2^SEL_W outputs. The outputs are registered on a single clock. A built-in dwell counter rotates the active output, which serves time-multiplexed selects such as display digit strobes or bank enables. It sits between control logic (select or scan configuration) and the multiplexed loads.

---
 rtl/onehot_scan_decoder.sv | 83 ++++++++
 tb/tb_onehot_scan_decoder.sv | 132 +++++++++++++
 2 files changed

// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot decoder with enable and dwell-timed auto-scan.
// Optional macro DECODER_BLANK_EN: when defined, en=0 blanks o instead of holding it.
module onehot_scan_decoder #(
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [DWELL_W-1:0]        dwell,
  output logic [(1 << SEL_W)-1:0]   o,
  output logic [SEL_W-1:0]          idx,
  output logic                      wrap
);

  localparam int unsigned OUT_W = 1 << SEL_W;

  logic [OUT_W-1:0]   o_q,    o_d;
  logic [SEL_W-1:0]   idx_q,  idx_d;
  logic [DWELL_W-1:0] cnt_q,  cnt_d;
  logic               mode_q, mode_d;
  logic               wrap_q, wrap_d;
  logic               scan_run;
  logic               last_idx;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
    onehot = OUT_W'(1) << i;
  endfunction

  assign scan_run = mode && mode_q;
  assign last_idx = (idx_q == SEL_W'(OUT_W - 1));

  // Next-state: direct/entry load sel, scan run counts dwell then steps idx.
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
`ifdef DECODER_BLANK_EN
    o_d    = '0;
`else
    o_d    = o_q;
`endif
    if (en) begin
      mode_d = mode;
      if (!scan_run) begin
        idx_d = sel;
        cnt_d = '0;
      end else if (cnt_q >= dwell) begin
        // >= so a dwell lowered below cnt advances immediately
        cnt_d  = '0;
        idx_d  = idx_q + SEL_W'(1);
        wrap_d = last_idx;
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end
      o_d = onehot(idx_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_q    <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      o_q    <= o_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      wrap_q <= wrap_d;
    end
  end

  assign o    = o_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Scoreboard bench for onehot_scan_decoder: SEL_W=2 and SEL_W=3 instances share stimulus.
module tb_onehot_scan_decoder;

  logic       clk = 1'b0;
  logic       rst, en, mode;
  logic [2:0] sel;
  logic [7:0] dwell;
  logic [3:0] o2;
  logic [1:0] idx2;
  logic       wrap2;
  logic [7:0] o3;
  logic [2:0] idx3;
  logic       wrap3;

  always #5 clk = ~clk;

  onehot_scan_decoder #(.SEL_W(2), .DWELL_W(8)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[1:0]), .dwell(dwell),
    .o(o2), .idx(idx2), .wrap(wrap2)
  );

  onehot_scan_decoder #(.SEL_W(3), .DWELL_W(8)) dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .dwell(dwell),
    .o(o3), .idx(idx3), .wrap(wrap3)
  );

`ifdef DECODER_BLANK_EN
  localparam logic [7:0] GAP_O = 8'h00;
`else
  localparam logic [7:0] GAP_O = 8'h02;
`endif

  typedef struct {
    logic [7:0] o;
    logic [2:0] idx;
    logic       wrap;
    logic       which;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Drive inputs on the falling edge, queue the value expected after the next rising edge.
  task automatic step(input logic r, input logic e, input logic m, input logic [2:0] s,
                      input logic [7:0] d, input logic [7:0] eo, input logic [2:0] ei,
                      input logic ew, input logic which, input string nm);
    exp_t x;
    rst = r; en = e; mode = m; sel = s; dwell = d;
    @(posedge clk);
    x.o = eo; x.idx = ei; x.wrap = ew; x.which = which; x.name = nm;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  // Monitor: one expectation per rising edge, sampled 1 time unit later.
  exp_t       cur;
  logic [7:0] got_o;
  logic [2:0] got_idx;
  logic       got_wrap;
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      cur      = exp_q.pop_front();
      got_o    = cur.which ? o3 : {4'b0, o2};
      got_idx  = cur.which ? idx3 : {1'b0, idx2};
      got_wrap = cur.which ? wrap3 : wrap2;
      n_tests++;
      if (got_o !== cur.o || got_idx !== cur.idx || got_wrap !== cur.wrap) begin
        n_fail++;
        $display("FAIL %s: got o=%b idx=%0d wrap=%b, required o=%b idx=%0d wrap=%b",
                 cur.name, got_o, got_idx, got_wrap, cur.o, cur.idx, cur.wrap);
      end
    end
  end

  initial begin
    logic [1:0] k_idx;
    rst = 1'b1; en = 1'b1; mode = 1'b1; sel = 3'd0; dwell = 8'd0;

    // Reset held two cycles with scan requested
    step(1, 1, 1, 3'd2, 8'd0, 8'h00, 3'd0, 0, 0, "reset_c1");
    step(1, 1, 1, 3'd2, 8'd0, 8'h00, 3'd0, 0, 0, "reset_c2");

    // Direct sweep on the 4-output instance
    step(0, 1, 0, 3'd0, 8'd0, 8'h01, 3'd0, 0, 0, "direct_0");
    step(0, 1, 0, 3'd1, 8'd0, 8'h02, 3'd1, 0, 0, "direct_1");
    step(0, 1, 0, 3'd2, 8'd0, 8'h04, 3'd2, 0, 0, "direct_2");
    step(0, 1, 0, 3'd3, 8'd0, 8'h08, 3'd3, 0, 0, "direct_3");

    // Scan from sel=2, dwell=2: three cycles per output, wrap on first 0001
    for (int k = 1; k <= 13; k++) begin
      k_idx = 2'(2 + (k - 1) / 3);
      step(0, 1, 1, 3'd2, 8'd2, 8'(4'b0001 << k_idx), {1'b0, k_idx}, (k == 7), 0,
           $sformatf("scan_k%0d", k));
    end

    // Enable gating mid-scan: enter at idx1 with dwell=3, reach cnt=1, gap 5 cycles
    step(0, 1, 0, 3'd0, 8'd3, 8'h01, 3'd0, 0, 0, "gate_direct");
    step(0, 1, 1, 3'd1, 8'd3, 8'h02, 3'd1, 0, 0, "gate_entry");
    step(0, 1, 1, 3'd1, 8'd3, 8'h02, 3'd1, 0, 0, "gate_cnt1");
    for (int k = 0; k < 5; k++)
      step(0, 0, 1, 3'd1, 8'd3, GAP_O, 3'd1, 0, 0, $sformatf("gate_off%0d", k));
    step(0, 1, 1, 3'd1, 8'd3, 8'h02, 3'd1, 0, 0, "gate_resume_cnt2");
    step(0, 1, 1, 3'd1, 8'd3, 8'h02, 3'd1, 0, 0, "gate_resume_cnt3");
    step(0, 1, 1, 3'd1, 8'd3, 8'h04, 3'd2, 0, 0, "gate_advance");

    // Dwell reduction on the 8-output instance
    step(0, 1, 0, 3'd0, 8'd7, 8'h01, 3'd0, 0, 1, "dw_direct");
    step(0, 1, 1, 3'd3, 8'd7, 8'h08, 3'd3, 0, 1, "dw_entry");
    for (int k = 1; k <= 5; k++)
      step(0, 1, 1, 3'd3, 8'd7, 8'h08, 3'd3, 0, 1, $sformatf("dw_cnt%0d", k));
    step(0, 1, 1, 3'd3, 8'd1, 8'h10, 3'd4, 0, 1, "dw_lowered_advance");
    step(0, 1, 1, 3'd3, 8'd1, 8'h10, 3'd4, 0, 1, "dw_mid_dwell");
    step(1, 1, 1, 3'd3, 8'd1, 8'h00, 3'd0, 0, 1, "dw_reset");
    step(0, 1, 0, 3'd5, 8'd1, 8'h20, 3'd5, 0, 1, "dw_direct_5");

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
